reg_transfer_unit: RTL and testbench

Register-transfer sequencer for the 6-bit CPU datapath, sitting directly upstream of the 8-to-1 6-bit bus multiplexer. It holds the eight 6-bit general registers that drive mux inputs i0..i7, drives the mux select, and captures the mux output back into a destination register. One operation runs at a time under a start/busy/done handshake, with an optional increment, decrement or immediate-load on the way through.

---
 rtl/cpu6_pkg.sv | 23 ++
 rtl/reg_transfer_unit_if.sv | 28 ++
 rtl/rtu_alu.sv | 26 ++
 rtl/reg_transfer_unit.sv | 93 +++++++++
 tb/tb_reg_transfer_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cpu6_pkg.sv
// Shared definitions for the 6-bit CPU datapath: widths, register-transfer
// opcodes and the sequencer state encoding.
package cpu6_pkg;

    localparam int WIDTH = 6;
    localparam int NREG  = 8;
    localparam int SELW  = $clog2(NREG);

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_INC = 2'b01,
        OP_DEC = 2'b10,
        OP_LDI = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SELECT = 2'b01,
        ST_WRITE  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/reg_transfer_unit_if.sv
// Request/response and mux-side signals of the register-transfer unit.
// The slave modport is the sequencer; the master modport drives requests and bus_in.
interface reg_transfer_unit_if #(
    parameter int WIDTH = 6,
    parameter int SELW  = 3
);
    logic             start;
    logic [1:0]       op;
    logic [SELW-1:0]  src;
    logic [SELW-1:0]  dst;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [SELW-1:0]  sel;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output start, op, src, dst, imm, bus_in,
        input  r0, r1, r2, r3, r4, r5, r6, r7, sel, busy, done, zero
    );

    modport slave (
        input  start, op, src, dst, imm, bus_in,
        output r0, r1, r2, r3, r4, r5, r6, r7, sel, busy, done, zero
    );
endinterface

// File: rtl/rtu_alu.sv
// Combinational result path for a register transfer: pass, increment,
// decrement (all mod 2^WIDTH) or immediate.
module rtu_alu
    import cpu6_pkg::*;
#(
    parameter int WIDTH = cpu6_pkg::WIDTH
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_bus,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        o_result = i_bus;
        case (i_op)
            OP_MOV:  o_result = i_bus;
            OP_INC:  o_result = i_bus + WIDTH'(1);
            OP_DEC:  o_result = i_bus - WIDTH'(1);
            OP_LDI:  o_result = i_imm;
            default: o_result = i_bus;
        endcase
    end

endmodule

// File: rtl/reg_transfer_unit.sv
// Register-transfer sequencer: eight general registers feeding the bus mux,
// mux select, and write-back of the (optionally modified) mux output.
module reg_transfer_unit
    import cpu6_pkg::*;
#(
    parameter int WIDTH = cpu6_pkg::WIDTH,
    parameter int NREG  = cpu6_pkg::NREG
) (
    input logic               clk,
    input logic               rst_n,
    reg_transfer_unit_if.slave bus
);

    localparam int SELW = $clog2(NREG);

    state_e            r_state;
    logic [WIDTH-1:0]  r_regs [NREG];
    op_e               r_op;
    logic [SELW-1:0]   r_dst;
    logic [WIDTH-1:0]  r_imm;
    logic [SELW-1:0]   r_sel;
    logic              r_busy;
    logic              r_done;
    logic              r_zero;
    logic [WIDTH-1:0]  w_result;

    rtu_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_op),
        .i_bus    (bus.bus_in),
        .i_imm    (r_imm),
        .o_result (w_result)
    );

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            // NOTE: the register file is flops, not RAM, so it is cleared by reset.
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_op    <= OP_MOV;
            r_dst   <= '0;
            r_imm   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op   <= op_e'(bus.op);
                        r_dst  <= bus.dst;
                        r_imm  <= bus.imm;
                        r_busy <= 1'b1;
                        if (op_e'(bus.op) == OP_LDI) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_sel   <= bus.src;
                            r_state <= ST_SELECT;
                        end
                    end
                end
                ST_SELECT: r_state <= ST_WRITE;
                ST_WRITE: begin
                    r_regs[r_dst] <= w_result;
                    r_zero        <= (w_result == '0);
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.r0   = r_regs[0];
    assign bus.r1   = r_regs[1];
    assign bus.r2   = r_regs[2];
    assign bus.r3   = r_regs[3];
    assign bus.r4   = r_regs[4];
    assign bus.r5   = r_regs[5];
    assign bus.r6   = r_regs[6];
    assign bus.r7   = r_regs[7];
    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.zero = r_zero;

endmodule

// File: tb/tb_reg_transfer_unit.sv
// Scoreboard bench for reg_transfer_unit: directed ops push expected writes,
// a done-driven monitor pops and compares the register file and zero flag.
module tb_reg_transfer_unit;
    import cpu6_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_transfer_unit_if #(.WIDTH(6), .SELW(3)) bus ();

    reg_transfer_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]      dst;
        logic [5:0]      val;
        logic            zero;
        logic [7:0][5:0] snap;
    } exp_t;

    exp_t            sb_q[$];
    logic [7:0][5:0] model = '0;
    int              checks = 0;
    int              errors = 0;

    function automatic logic [5:0] dut_reg(input int i);
        case (i)
            0: return bus.r0;
            1: return bus.r1;
            2: return bus.r2;
            3: return bus.r3;
            4: return bus.r4;
            5: return bus.r5;
            6: return bus.r6;
            default: return bus.r7;
        endcase
    endfunction

    function automatic logic [47:0] dut_file();
        return {bus.r7, bus.r6, bus.r5, bus.r4, bus.r3, bus.r2, bus.r1, bus.r0};
    endfunction

    // Behavioral 8-to-1 mux downstream of the unit.
    always_comb bus.bus_in = dut_reg(int'(bus.sel));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [2:0] dst, input logic [5:0] val);
        exp_t e;
        model[dst] = val;
        e.dst  = dst;
        e.val  = val;
        e.zero = (val == 6'd0);
        e.snap = model;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("wr_value", dut_reg(int'(e.dst)), e.val);
                check("zero_flag", bus.zero, e.zero);
                check("reg_file", dut_file(), e.snap);
            end
        end
    end

    // One operation with timing checks; inject pulses start during SELECT and DONE.
    task automatic run_op(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                          input logic [5:0] imm, input logic [5:0] exp_val, input bit inject);
        logic [5:0] pre;
        pre = model[dst];
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src = src; bus.dst = dst; bus.imm = imm;
        expect_wr(dst, exp_val);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = ~op; bus.src = ~src; bus.dst = ~dst; bus.imm = ~imm;
        check("accept_busy", bus.busy, 1);
        check("accept_no_done", bus.done, 0);
        if (op != OP_LDI) begin
            check("select_sel", bus.sel, src);
            if (inject) begin
                @(negedge clk);
                bus.start = 1'b1; bus.op = OP_LDI; bus.dst = 3'd0; bus.imm = 6'd9;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("write_busy", bus.busy, 1);
        end
        check("write_pre_value", dut_reg(int'(dst)), pre);
        @(posedge clk); #1;
        check("done_high", bus.done, 1);
        check("done_busy_low", bus.busy, 0);
        check("write_latency", dut_reg(int'(dst)), exp_val);
        if (inject) begin
            @(negedge clk);
            bus.start = 1'b1; bus.op = OP_LDI; bus.dst = 3'd0; bus.imm = 6'd9;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("done_one_cycle", bus.done, 0);
        check("idle_not_busy", bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.src = 3'd0; bus.dst = 3'd0; bus.imm = 6'd0;

        repeat (3) @(posedge clk); #1;
        check("rst_regs", dut_file(), 48'd0);
        check("rst_sel", bus.sel, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_zero", bus.zero, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_regs", dut_file(), 48'd0);
        check("post_rst_busy", bus.busy, 0);

        // Reset asserted while LDI r3<-17 is in WRITE: the write must be dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_LDI; bus.dst = 3'd3; bus.imm = 6'd17;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("abort_inflight_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_r3", bus.r3, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("abort_r3_after", bus.r3, 0);
        check("abort_idle", bus.busy, 0);

        run_op(OP_LDI, 3'd0, 3'd2, 6'd45, 6'd45, 1'b0);
        run_op(OP_MOV, 3'd2, 3'd5, 6'd0,  6'd45, 1'b0);
        run_op(OP_LDI, 3'd0, 3'd7, 6'd63, 6'd63, 1'b0);
        check("sel_hold_idle", bus.sel, 2);
        run_op(OP_INC, 3'd7, 3'd7, 6'd0,  6'd0,  1'b0);
        run_op(OP_DEC, 3'd0, 3'd1, 6'd0,  6'd63, 1'b0);
        run_op(OP_MOV, 3'd5, 3'd6, 6'd0,  6'd45, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("ignored_start_idle", bus.busy, 0);
        check("ignored_start_r0", bus.r0, 0);
        run_op(OP_MOV, 3'd3, 3'd3, 6'd0,  6'd0,  1'b0);

        // start held high: INC r4 in place, re-accepted every 4 cycles.
        expect_wr(3'd4, 6'd1);
        expect_wr(3'd4, 6'd2);
        expect_wr(3'd4, 6'd3);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_INC; bus.src = 3'd4; bus.dst = 3'd4; bus.imm = 6'd0;
        @(posedge clk); #1;
        check("held_first_busy", bus.busy, 1);
        repeat (4) @(posedge clk); #1;
        check("held_reaccept_1", bus.busy, 1);
        check("held_r4_1", bus.r4, 1);
        repeat (4) @(posedge clk); #1;
        bus.start = 1'b0;
        check("held_reaccept_2", bus.busy, 1);
        check("held_r4_2", bus.r4, 2);
        repeat (4) @(posedge clk); #1;
        check("held_stop_busy", bus.busy, 0);
        check("held_r4_3", bus.r4, 3);
        repeat (4) @(posedge clk); #1;
        check("held_r4_final", bus.r4, 3);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule
